// File: rtl/soc_mem_arbiter.sv
// rtl/soc_mem_arbiter.sv - two-port round-robin data memory arbiter with port 1 burst lock
// Port 1 may hold the memory for up to MAX_BURST beats, after which port 0 gets one forced turn.
module soc_mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_valid,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_wmask,
  output logic            m0_ready,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_valid,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wmask,
  input  logic            m1_lock,
  output logic            m1_ready,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {ARB, LOCK1, RELEASE} state_t;

  state_t        state_q, state_d;
  logic          pri_q, pri_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_tag_q, rd_tag_d;
  logic          win0, win1;
  logic          gnt0, gnt1;

  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    case (state_q)
      ARB: begin
        win1 = m1_valid & (~m0_valid | pri_q);
        win0 = m0_valid & ~win1;
      end
      LOCK1: win1 = m1_valid;
      RELEASE: begin
        win0 = m0_valid;
        win1 = m1_valid & ~m0_valid;
      end
      default: ;
    endcase
  end

  // Grants are also masked by reset so nothing is accepted while it is asserted.
  assign gnt0 = win0 & rst;
  assign gnt1 = win1 & rst;

  always_comb begin
    state_d   = state_q;
    pri_d     = pri_q;
    cnt_d     = cnt_q;
    rd_pend_d = (gnt0 & ~m0_we) | (gnt1 & ~m1_we);
    rd_tag_d  = gnt1;
    case (state_q)
      ARB: begin
        if (gnt0) pri_d = 1'b1;
        if (gnt1) begin
          pri_d = 1'b0;
          if (m1_lock) begin
            state_d = LOCK1;
            cnt_d   = CW'(1);
          end
        end
      end
      LOCK1: begin
        if (gnt1) begin
          if (m1_lock && (cnt_q < CW'(MAX_BURST - 1))) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            state_d = RELEASE;
            cnt_d   = '0;
          end
        end
      end
      RELEASE: begin
        state_d = ARB;
        pri_d   = 1'b1;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ARB;
      pri_q     <= 1'b0;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pri_q     <= pri_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
    end
  end

  assign m0_ready  = gnt0;
  assign m1_ready  = gnt1;
  assign mem_en    = gnt0 | gnt1;
  assign mem_we    = gnt1 ? m1_we : (gnt0 & m0_we);
  assign mem_addr  = gnt1 ? m1_addr  : m0_addr;
  assign mem_wdata = gnt1 ? m1_wdata : m0_wdata;
  assign mem_wmask = gnt1 ? m1_wmask : m0_wmask;

  assign m0_rvalid = rd_pend_q & ~rd_tag_q;
  assign m1_rvalid = rd_pend_q & rd_tag_q;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// tb/tb_soc_mem_arbiter.sv - self-checking bench for soc_mem_arbiter
// A per-cycle reference model plus directed grant-sequence and read-data expectations.
module tb_soc_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_valid, m0_we, m0_ready, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic [3:0]    m0_wmask;
  logic          m1_valid, m1_we, m1_lock, m1_ready, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [3:0]    m1_wmask;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wmask;
  logic [DW-1:0] mem_rdata = '0;

  soc_mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wmask(m0_wmask), .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wmask(m1_wmask), .m1_lock(m1_lock), .m1_ready(m1_ready), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dfn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory stand-in: read data is a fixed function of the address, one cycle later.
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= dfn(mem_addr);
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // Reference model: tie-break favour, lock beat count, pending forced turn for port 0.
  bit         lock_m = 0;
  bit         rel_m = 0;
  int         lock_beats = 0;
  int         favor = 0;
  logic [1:0] exp_rv = 2'b00;
  logic [31:0] exp_rd = '0;

  always @(negedge clk) begin
    int          win;
    logic        s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wmask;
    if (!rst) begin
      chk("rst_m0_ready", m0_ready, 0);
      chk("rst_m1_ready", m1_ready, 0);
      chk("rst_m0_rvalid", m0_rvalid, 0);
      chk("rst_m1_rvalid", m1_rvalid, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      lock_m = 0; rel_m = 0; lock_beats = 0; favor = 0; exp_rv = 2'b00;
    end else begin
      if (rel_m) win = m0_valid ? 0 : (m1_valid ? 1 : -1);
      else if (lock_m) win = m1_valid ? 1 : -1;
      else if (m0_valid && m1_valid) win = favor;
      else win = m0_valid ? 0 : (m1_valid ? 1 : -1);
      s_we    = (win == 1) ? m1_we    : m0_we;
      s_addr  = (win == 1) ? m1_addr  : m0_addr;
      s_wdata = (win == 1) ? m1_wdata : m0_wdata;
      s_wmask = (win == 1) ? m1_wmask : m0_wmask;
      chk("m0_ready", m0_ready, (win == 0));
      chk("m1_ready", m1_ready, (win == 1));
      chk("mem_en", mem_en, (win >= 0));
      if (win >= 0) begin
        chk("mem_we", mem_we, s_we);
        chk("mem_addr", mem_addr, s_addr);
        if (s_we) begin
          chk("mem_wdata", mem_wdata, s_wdata);
          chk("mem_wmask", mem_wmask, s_wmask);
        end
      end else begin
        chk("mem_we_idle", mem_we, 0);
      end
      chk("m0_rvalid", m0_rvalid, exp_rv[0]);
      chk("m1_rvalid", m1_rvalid, exp_rv[1]);
      if (exp_rv[0]) chk("m0_rdata", m0_rdata, exp_rd);
      if (exp_rv[1]) chk("m1_rdata", m1_rdata, exp_rd);

      exp_rv = 2'b00;
      if (win >= 0 && !s_we) begin
        exp_rv[win] = 1'b1;
        exp_rd = dfn(s_addr);
      end
      if (rel_m) begin
        rel_m = 0;
        favor = 1;
      end else if (lock_m) begin
        if (win == 1) begin
          lock_beats++;
          if (!m1_lock || lock_beats == MB) begin
            lock_m = 0;
            rel_m = 1;
          end
        end
      end else if (win >= 0) begin
        favor = 1 - win;
        if (win == 1 && m1_lock) begin
          lock_m = 1;
          lock_beats = 1;
        end
      end
    end
  end

  // Stimulus-side observations, taken at the same sampling point as the model.
  bit          acc0, acc1, rv0, rv1;
  logic [31:0] rd0, rd1;
  int          glog[$];

  task automatic step();
    @(negedge clk);
    acc0 = m0_valid && m0_ready;
    acc1 = m1_valid && m1_ready;
    rv0 = m0_rvalid; rv1 = m1_rvalid;
    rd0 = m0_rdata;  rd1 = m1_rdata;
    glog.push_back(acc0 ? 0 : (acc1 ? 1 : -1));
    @(posedge clk);
    #1;
  endtask

  task automatic check_seq(input string name, input int exp[$]);
    chk($sformatf("%s_len", name), glog.size(), exp.size());
    for (int i = 0; i < exp.size() && i < glog.size(); i++)
      chk($sformatf("%s_grant%0d", name, i), glog[i], exp[i]);
  endtask

  initial begin
    int e[$];
    int idx;
    rst = 0;
    m0_valid = 1; m0_we = 0; m0_addr = 32'h100; m0_wdata = 32'h0; m0_wmask = 4'hF;
    m1_valid = 1; m1_we = 0; m1_addr = 32'h200; m1_wdata = 32'h0; m1_wmask = 4'hF;
    m1_lock = 0;

    step(); step();
    chk("reset_acc0", acc0, 0);
    chk("reset_acc1", acc1, 0);

    // Round-robin reads after reset release.
    rst = 1;
    glog.delete();
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 1) begin
        chk("rr_m0_rvalid", rv0, 1);
        chk("rr_m0_rdata_lit", rd0, 32'h0100FEFF);
      end
      if (i == 2) begin
        chk("rr_m1_rvalid", rv1, 1);
        chk("rr_m1_rdata_lit", rd1, 32'h0200FDFF);
      end
    end
    e = '{0, 1, 0, 1};
    check_seq("rr", e);

    // Four-beat locked write burst from port 1 against a busy port 0.
    m0_addr = 32'h104;
    m1_we = 1; m1_wmask = 4'h3;
    glog.delete();
    idx = 0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      m1_addr  = 32'h300 + 4 * idx;
      m1_wdata = 32'hA000_0000 + idx;
      m1_lock  = (idx < 3);
      step();
      if (acc1) idx++;
    end
    chk("lock_burst_done", idx, 4);
    m1_valid = 0; m1_lock = 0;
    step();
    e = '{0, 1, 1, 1, 1, 0};
    check_seq("lock_burst", e);
    m0_valid = 0;
    step();

    // Burst cap: continuous lock is cut off after MB beats.
    m0_valid = 1; m1_valid = 1; m1_lock = 1; m1_wmask = 4'hC; m1_addr = 32'h800;
    glog.delete();
    for (int c = 0; c < MB + 1; c++) begin
      m1_wdata = 32'hB000_0000 + c;
      step();
      if (acc1) m1_addr = m1_addr + 4;
    end
    m1_lock = 0;
    repeat (4) step();
    e.delete();
    repeat (MB) e.push_back(1);
    e.push_back(0);
    e.push_back(1); e.push_back(0); e.push_back(1); e.push_back(0);
    check_seq("burst_cap", e);
    m0_valid = 0; m1_valid = 0;
    step();

    // Lock stall: port 1 pauses mid-burst; port 0 stays locked out.
    m0_valid = 1; m1_lock = 1; m1_addr = 32'hC00;
    glog.delete();
    for (int c = 0; c < MB + 3; c++) begin
      m1_valid = !(c >= 2 && c < 5);
      m1_wdata = 32'hC000_0000 + c;
      step();
      if (acc1) m1_addr = m1_addr + 4;
    end
    m1_valid = 0;
    step();
    e = '{1, 1, -1, -1, -1};
    repeat (MB - 2) e.push_back(1);
    e.push_back(0);
    check_seq("lock_stall", e);
    m0_valid = 0; m1_lock = 0;
    step();

    // Asynchronous reset with a port 1 read in flight.
    m1_valid = 1; m1_we = 0; m1_addr = 32'h400;
    @(negedge clk);
    chk("ar_accept", m1_valid && m1_ready, 1);
    #2 rst = 0;
    @(posedge clk);
    #1;
    m1_valid = 0;
    step();
    chk("ar_rvalid_in_reset", rv1, 0);
    rst = 1;
    m0_valid = 1; m0_addr = 32'h500;
    m1_valid = 1; m1_addr = 32'h600;
    glog.delete();
    step();
    chk("ar_no_stale_rvalid", rv1, 0);
    chk("ar_first_grant_p0", glog[0], 0);
    m0_valid = 0;
    step();
    chk("ar_m0_rvalid", rv0, 1);
    chk("ar_m0_rdata_lit", rd0, 32'h0500FAFF);
    m1_valid = 0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/soc_mem_arbiter.md
# soc_mem_arbiter

Two-port arbiter that shares the SoC's single-port synchronous data memory between the CPU load/store unit (port 0) and the accelerator DMA (port 1). Round-robin between ports on single beats; port 1 may lock the memory for bounded bursts. It routes 1-cycle-latency read data back to the issuing port. Sits inside `soc` between both masters and the data RAM.

## Interface
- AW, 32, address width (byte address)
- DW, 32, data width; DW/8 byte lanes
- MAX_BURST, 16, max consecutive beats port 1 may hold under lock (>=2)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- m0_valid, m1_valid  in  1  request present
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  AW  byte address, passed unmodified
- m0_wdata, m1_wdata  in  DW  write data
- m0_wmask, m1_wmask  in  DW/8  byte enables (ignored on reads)
- m1_lock  in  1  port 1 requests that the grant be held for the next beat
- m0_ready, m1_ready  out  1  request accepted this cycle (valid & ready = beat)
- m0_rvalid, m1_rvalid  out  1  read data valid for that port
- m0_rdata, m1_rdata  out  DW  read data (mem_rdata fanned out; meaningful only when rvalid)
- mem_en  out  1  memory access this cycle
- mem_we, mem_addr, mem_wdata, mem_wmask  out  1/AW/DW/DW/8  muxed from the winning port
- mem_rdata  in  DW  memory read data, valid the cycle after a read with mem_en

## Operation
- States: ARB (normal round-robin), LOCK1 (port 1 holds memory), RELEASE (one-cycle forced priority to port 0).
- ARB: if only one port is valid, it wins. If both are valid, the port named by the priority pointer `pri` wins. After each beat, `pri` moves to the other port.
- Port 1 beat accepted with m1_lock=1 in ARB -> LOCK1; burst counter = 1.
- LOCK1: only port 1 can win; m0_ready=0.
  - Port 1 beat with m1_lock=1 and counter < MAX_BURST-1 -> counter+1, stay in LOCK1.
  - Port 1 beat with m1_lock=0, or the beat that brings counter to MAX_BURST -> RELEASE.
  - m1_valid=0 holds the state and the counter. Port 1 must not drop the lock without a final beat.
- RELEASE: port 0 wins if valid, else port 1 (lock ignored; no new lock is taken this cycle). Then -> ARB with pri=port 1.
- The winning port gets ready=1 in the same cycle. mem_en = valid & ready of the winner. The mem_* fields are muxed from the winner. When mem_en=0, mem_we is driven 0.
- Read return: a registered owner tag is captured on every read beat. The next cycle, the tagged port's rvalid=1 with rdata=mem_rdata. Back-to-back reads from alternating ports return in issue order.
- Write beats produce no rvalid.

## Timing
- Reset (rst=0, asynchronous): state=ARB, pri=port 0, counter=0, read-pending flag=0.
  - All of m*_ready, m*_rvalid, mem_en, mem_we = 0.
- Reset mid-burst or with a read in flight drops the lock and the pending rvalid. No rvalid is issued after reset release.
- ready and mem_* are combinational from the valid inputs and the registered state; accept latency is 0 cycles.
- Read latency: 1 cycle from accept to rvalid.
- Throughput: 1 beat per cycle. Port 0 worst-case wait under contention is MAX_BURST beats + 1 cycle.
- Requesters keep valid and request fields stable until ready. The arbiter tolerates valid being withdrawn while not ready.

## Test plan
- Reset: hold rst=0 with both valids high -> both readys, both rvalids and mem_en = 0. Release -> first contended cycle grants port 0.
- Round-robin: both ports issue continuous reads (m0 addr 0x100, m1 addr 0x200, lock=0) -> grants alternate 0,1,0,1. Each rvalid arrives 1 cycle after accept on the correct port with the matching data.
- Locked burst: m1 issues 4 writes with lock=1,1,1,0 while m0_valid=1 -> m1 gets 4 consecutive beats, then m0 is granted in the RELEASE cycle.
- Burst cap: MAX_BURST=16, m1 holds lock=1 continuously, m0_valid=1 -> exactly 16 m1 beats, then 1 m0 beat, then alternation resumes.
- Lock stall: in LOCK1, m1_valid drops for 3 cycles -> mem_en=0 and m0_ready=0 for those cycles. The counter is preserved and the burst ends at MAX_BURST total beats.
- Async reset mid-read: a port 1 read is accepted, then rst falls before the next clock edge -> m1_rvalid stays 0. After release, state=ARB and pri=port 0.
